// File: rtl/nibble_packer.sv
// nibble_packer: packs a valid/ready nibble stream into bytes behind a small FWFT byte FIFO
module nibble_packer #(
    parameter int DEPTH      = 4,
    parameter bit HIGH_FIRST = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [3:0]               in_nibble_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic                     flush_i,
    output logic [7:0]               out_byte_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     half_held_o
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {EMPTY, HALF, FLUSH_PEND} state_t;

    state_t        state_q, state_d;
    logic [3:0]    hold_q, hold_d;
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   level_q, level_d;
    logic          full, accept, pop, push;
    logic [7:0]    push_byte;

    assign full        = level_q == (AW+1)'(DEPTH);
    assign in_ready_o  = rst_n && (state_q == EMPTY || (state_q == HALF && !full && !flush_i));
    assign accept      = in_valid_i && in_ready_o;
    assign out_valid_o = level_q != '0;
    assign pop         = out_valid_o && out_ready_i;
    assign out_byte_o  = out_valid_o ? mem_q[rd_q] : 8'h00;
    assign level_o     = level_q;
    assign half_held_o = state_q != EMPTY;
    assign level_d     = level_q + (AW+1)'(push) - (AW+1)'(pop);

    // Pack decision: hold the first nibble, push a full or padded byte, park a blocked flush
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        push      = 1'b0;
        push_byte = HIGH_FIRST ? {hold_q, 4'h0} : {4'h0, hold_q};
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    hold_d  = in_nibble_i;
                    state_d = HALF;
                end
            end
            HALF: begin
                if (flush_i) begin
                    push    = !full;
                    state_d = full ? FLUSH_PEND : EMPTY;
                end else if (accept) begin
                    push      = 1'b1;
                    push_byte = HIGH_FIRST ? {hold_q, in_nibble_i} : {in_nibble_i, hold_q};
                    state_d   = EMPTY;
                end
            end
            FLUSH_PEND: begin
                // a pop in the same cycle frees the slot the padded byte lands in
                if (!full || pop) begin
                    push    = 1'b1;
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // State, held nibble and FIFO storage/pointers; reset drops everything buffered
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            hold_q  <= 4'h0;
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            level_q <= level_d;
            if (push) begin
                mem_q[wr_q] <= push_byte;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_nibble_packer.sv
// tb_nibble_packer: directed + random checks of nibble_packer against a queue-based model
module tb_nibble_packer;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] nib;
    logic       in_valid, flush, out_ready;
    logic       ir0, ov0, hh0, ir1, ov1, hh1;
    logic [7:0] ob0, ob1;
    logic [2:0] lv0, lv1;

    int vectors = 0;
    int errs    = 0;

    bit         m_held, m_pend;
    logic [3:0] m_hn;
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    always #5 clk = ~clk;

    nibble_packer #(.DEPTH(DEPTH), .HIGH_FIRST(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_nibble_i(nib), .in_valid_i(in_valid), .in_ready_o(ir0),
        .flush_i(flush), .out_byte_o(ob0), .out_valid_o(ov0), .out_ready_i(out_ready),
        .level_o(lv0), .half_held_o(hh0));

    nibble_packer #(.DEPTH(DEPTH), .HIGH_FIRST(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_nibble_i(nib), .in_valid_i(in_valid), .in_ready_o(ir1),
        .flush_i(flush), .out_byte_o(ob1), .out_valid_o(ov1), .out_ready_i(out_ready),
        .level_o(lv1), .half_held_o(hh1));

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        int         n;
        bit         full, exp_ir;
        logic [7:0] h0, h1;
        n      = q0.size();
        full   = n == DEPTH;
        exp_ir = rst_n && (!m_held || (!m_pend && !full && !flush));
        h0     = n != 0 ? q0[0] : 8'h00;
        h1     = n != 0 ? q1[0] : 8'h00;
        chk("in_ready", 8'(ir0), 8'(exp_ir));
        chk("out_valid", 8'(ov0), 8'(n != 0));
        chk("out_byte_lo", ob0, h0);
        chk("level", 8'(lv0), 8'(n));
        chk("half_held", 8'(hh0), 8'(m_held));
        chk("in_ready_hi", 8'(ir1), 8'(exp_ir));
        chk("out_valid_hi", 8'(ov1), 8'(n != 0));
        chk("out_byte_hi", ob1, h1);
        chk("level_hi", 8'(lv1), 8'(n));
        chk("half_held_hi", 8'(hh1), 8'(m_held));
    endtask

    // Reference: one held nibble, a pending-flush flag and a byte queue per nibble order
    task automatic model_edge();
        bit         full, pop, psh;
        logic [7:0] b0, b1;
        if (!rst_n) begin
            m_held = 0; m_pend = 0; m_hn = 4'h0;
            q0.delete(); q1.delete();
            return;
        end
        full = q0.size() == DEPTH;
        pop  = q0.size() != 0 && out_ready;
        psh  = 0;
        b0   = {4'h0, m_hn};
        b1   = {m_hn, 4'h0};
        if (!m_held) begin
            if (in_valid) begin m_hn = nib; m_held = 1; end
        end else if (!m_pend) begin
            if (flush) begin
                if (!full) begin psh = 1; m_held = 0; end
                else m_pend = 1;
            end else if (in_valid && !full) begin
                psh = 1; b0 = {nib, m_hn}; b1 = {m_hn, nib}; m_held = 0;
            end
        end else if (!full || pop) begin
            psh = 1; m_held = 0; m_pend = 0;
        end
        if (pop) begin void'(q0.pop_front()); void'(q1.pop_front()); end
        if (psh) begin q0.push_back(b0); q1.push_back(b1); end
    endtask

    task automatic step();
        #1;
        check_all();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 0; nib = 4'h0; in_valid = 0; flush = 0; out_ready = 0;
        m_held = 0; m_pend = 0; m_hn = 4'h0;
        @(negedge clk);
        step();
        step();
        rst_n = 1;
        #1;
        chk("in_ready_after_reset", 8'(ir0), 8'h01);

        // basic pack
        out_ready = 1; in_valid = 1; nib = 4'h3;
        step();
        nib = 4'hA;
        step();
        in_valid = 0;
        #1;
        chk("basic_byte", ob0, 8'hA3);
        chk("basic_level", 8'(lv0), 8'h01);
        step();
        #1;
        chk("basic_drained", 8'(lv0), 8'h00);

        // backpressure: ten nibbles into a four-byte FIFO
        out_ready = 0; in_valid = 1;
        for (int i = 0; i < 10; i++) begin
            nib = 4'(i);
            step();
        end
        #1;
        chk("bp_level_full", 8'(lv0), 8'h04);
        chk("bp_in_ready", 8'(ir0), 8'h00);
        chk("bp_half", 8'(hh0), 8'h01);
        out_ready = 1; nib = 4'h9;
        step();
        step();
        in_valid = 0;
        for (int i = 0; i < 6; i++) step();

        // flush with a held nibble, then flush while empty
        out_ready = 0; in_valid = 1; nib = 4'h7;
        step();
        in_valid = 0; flush = 1;
        step();
        flush = 0;
        #1;
        chk("flush_lo", ob0, 8'h07);
        chk("flush_hi", ob1, 8'h70);
        chk("flush_half", 8'(hh0), 8'h00);
        out_ready = 1;
        step();
        flush = 1;
        step();
        flush = 0;
        #1;
        chk("flush_empty_level", 8'(lv0), 8'h00);

        // flush while full parks, then lands on the pop edge
        out_ready = 0; in_valid = 1;
        for (int i = 0; i < 9; i++) begin
            nib = 4'($urandom_range(15));
            step();
        end
        in_valid = 0; flush = 1;
        step();
        flush = 0;
        #1;
        chk("pend_in_ready", 8'(ir0), 8'h00);
        chk("pend_half", 8'(hh0), 8'h01);
        chk("pend_level", 8'(lv0), 8'h04);
        out_ready = 1;
        step();
        #1;
        chk("pend_push_level", 8'(lv0), 8'h04);
        chk("pend_cleared", 8'(hh0), 8'h00);
        for (int i = 0; i < 5; i++) step();

        // simultaneous push and pop at level 2, wrapping the pointers
        out_ready = 0; in_valid = 1;
        for (int i = 0; i < 4; i++) begin
            nib = 4'($urandom_range(15));
            step();
        end
        for (int i = 0; i < 3 * DEPTH; i++) begin
            out_ready = 0; nib = 4'($urandom_range(15));
            step();
            out_ready = 1; nib = 4'($urandom_range(15));
            step();
            #1;
            chk("pushpop_level", 8'(lv0), 8'h02);
        end
        in_valid = 0;
        for (int i = 0; i < 3; i++) step();

        // reset mid-stream
        out_ready = 0; in_valid = 1;
        for (int i = 0; i < 7; i++) begin
            nib = 4'($urandom_range(15));
            step();
        end
        in_valid = 0; rst_n = 0;
        step();
        rst_n = 1;
        #1;
        chk("rst_level", 8'(lv0), 8'h00);
        chk("rst_out_valid", 8'(ov0), 8'h00);
        chk("rst_half", 8'(hh0), 8'h00);
        chk("rst_in_ready", 8'(ir0), 8'h01);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rst_n     = $urandom_range(99) != 0;
            in_valid  = $urandom_range(3) != 0;
            nib       = 4'($urandom_range(15));
            flush     = $urandom_range(9) == 0;
            out_ready = $urandom_range(2) != 0;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
